sobel_line_buffer: RTL and testbench

//  Converts the raster-order 8-bit grayscale pixel stream into 3-row pixel columns for the 3x3 sobel window.

---
 rtl/sobel_line_buffer.sv | 159 +++++++++++++++
 tb/tb_sobel_line_buffer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_line_buffer.sv
// sobel_line_buffer
// Turns a raster-order grayscale pixel stream into 3-row columns
// {row r, row r-1, row r-2} for a 3x3 sobel window. Two line memories hold
// the previous two rows. A single output register sits in front of the
// downstream FIFO.
//
// Optional feature: define LINE_BUFFER_ZERO_PAD_EN to also emit columns
// during the first two rows of each frame. Missing rows above the image read
// as zero, so every pixel produces one column.
//
// Handshake: a pixel is consumed on a rising edge where in_rd_en=1, and
// in_rd_en is never high while in_empty=1. A column is pushed on a rising edge
// where out_wr_en=1, and out_wr_en is never high while out_full=1. out_din is
// held stable until it is pushed.
module sobel_line_buffer #(
  parameter int IMG_WIDTH  = 720,
  parameter int IMG_HEIGHT = 540,
  parameter int DWIDTH     = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [DWIDTH-1:0]   in_dout,
  input  logic                in_empty,
  output logic                in_rd_en,
  output logic [3*DWIDTH-1:0] out_din,
  input  logic                out_full,
  output logic                out_wr_en,
  output logic                frame_done,
  output logic                o_dbg_state
);

  localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [CW-1:0] LAST_COL = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(IMG_HEIGHT - 1);
  localparam logic [RW-1:0] FILL_END_ROW = RW'(1);

  // FILL covers rows 0..1 (line memories not yet primed), STREAM covers the rest.
  typedef enum logic {
    FILL   = 1'b0,
    STREAM = 1'b1
  } state_t;

  state_t                r_state;
  logic [CW-1:0]         r_col;
  logic [RW-1:0]         r_row;
  logic [3*DWIDTH-1:0]   r_out_din;
  logic                  r_out_valid;
  logic                  r_frame_done;

  // Line memories: r_line_a holds row r-2, r_line_b holds row r-1.
  // They are never cleared; row counting keeps stale data from being emitted.
  logic [DWIDTH-1:0]     r_line_a [IMG_WIDTH];
  logic [DWIDTH-1:0]     r_line_b [IMG_WIDTH];

  logic                  w_wr_en;
  logic                  w_free;
  logic                  w_consume;
  logic                  w_last_col;
  logic                  w_last_row;
  logic                  w_load;
  logic [DWIDTH-1:0]     w_tap_a;
  logic [DWIDTH-1:0]     w_tap_b;
  logic [3*DWIDTH-1:0]   w_load_din;

  assign w_tap_a    = r_line_a[r_col];
  assign w_tap_b    = r_line_b[r_col];
  assign w_last_col = (r_col == LAST_COL);
  assign w_last_row = (r_row == LAST_ROW);

  // Output register can take a new column if it is empty or being drained now.
  assign w_wr_en = r_out_valid & ~out_full;
  assign w_free  = ~r_out_valid | w_wr_en;

`ifdef LINE_BUFFER_ZERO_PAD_EN
  // Every consume produces a column, so consumption always waits for room.
  assign in_rd_en  = ~in_empty & w_free;
  assign w_consume = in_rd_en;
  assign w_load    = w_consume;

  // Rows above the image read as zero while the line memories are priming.
  always_comb begin
    w_load_din = {in_dout, w_tap_b, w_tap_a};
    if (r_state == FILL) begin
      if (r_row == '0) begin
        w_load_din = {in_dout, {DWIDTH{1'b0}}, {DWIDTH{1'b0}}};
      end else begin
        w_load_din = {in_dout, w_tap_b, {DWIDTH{1'b0}}};
      end
    end
  end
`else
  // FILL consumes freely; only STREAM consumes need space in the output register.
  assign in_rd_en   = ~in_empty & ((r_state == FILL) | w_free);
  assign w_consume  = in_rd_en;
  assign w_load     = w_consume & (r_state == STREAM);
  assign w_load_din = {in_dout, w_tap_b, w_tap_a};
`endif

  assign out_din     = r_out_din;
  assign out_wr_en   = w_wr_en;
  assign frame_done  = r_frame_done;
  assign o_dbg_state = r_state;

  // Shift the consumed column through the two line memories.
  always_ff @(posedge clock) begin
    if (w_consume) begin
      r_line_a[r_col] <= r_line_b[r_col];
      r_line_b[r_col] <= in_dout;
    end
  end

  // Position counters and FILL/STREAM state, advanced on every consume.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= FILL;
      r_col   <= '0;
      r_row   <= '0;
    end else if (w_consume) begin
      if (w_last_col) begin
        r_col <= '0;
        if (w_last_row) begin
          r_row   <= '0;
          r_state <= FILL;
        end else begin
          r_row <= r_row + RW'(1);
          if (r_row == FILL_END_ROW) begin
            r_state <= STREAM;
          end
        end
      end else begin
        r_col <= r_col + CW'(1);
      end
    end
  end

  // Output register: load on a column-producing consume, else clear when pushed.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_out_din   <= '0;
      r_out_valid <= 1'b0;
    end else if (w_load) begin
      r_out_din   <= w_load_din;
      r_out_valid <= 1'b1;
    end else if (w_wr_en) begin
      r_out_valid <= 1'b0;
    end
  end

  // One-cycle pulse after the last pixel of a frame is consumed.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_consume & w_last_col & w_last_row;
    end
  end

endmodule

// File: tb/tb_sobel_line_buffer.sv
// tb_sobel_line_buffer
// Bench for sobel_line_buffer at a 4x4 image. A frame-array model builds the
// expected column stream from consumed pixels and a scoreboard compares every
// pushed column. Literal values pin the model on the pattern 16*row+col.
module tb_sobel_line_buffer;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int DW = 8;
`ifdef LINE_BUFFER_ZERO_PAD_EN
  localparam int NOUT = W * H;
`else
  localparam int NOUT = W * (H - 2);
`endif

  // ---------------- clock / reset ----------------
  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic [DW-1:0]   in_dout = '0;
  logic            in_empty = 1'b1;
  logic            in_rd_en;
  logic [3*DW-1:0] out_din;
  logic            out_full = 1'b0;
  logic            out_wr_en;
  logic            frame_done;
  logic            o_dbg_state;

  always #5 clock = ~clock;

  sobel_line_buffer #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DWIDTH(DW)) dut (
    .clock       (clock),
    .reset       (reset),
    .in_dout     (in_dout),
    .in_empty    (in_empty),
    .in_rd_en    (in_rd_en),
    .out_din     (out_din),
    .out_full    (out_full),
    .out_wr_en   (out_wr_en),
    .frame_done  (frame_done),
    .o_dbg_state (o_dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  // ---------------- source driver ----------------
  logic [DW-1:0] src_q[$];
  int  empty_mode = 0;  // 0 always offer, 1 toggle, 2 random gaps
  int  full_mode  = 0;  // 0 never full, 1 random full
  bit  force_full = 0;
  bit  took       = 0;
  bit  tog        = 0;

  // Inputs change 1 time unit after the rising edge; pop what was consumed.
  always @(posedge clock) begin
    bit want;
    #1;
    if (took && src_q.size() > 0) void'(src_q.pop_front());
    took = 0;
    case (empty_mode)
      1:       begin tog = ~tog; want = tog; end
      2:       want = ($urandom_range(0, 3) != 0);
      default: want = 1'b1;
    endcase
    in_empty = !(want && src_q.size() > 0);
    in_dout  = (src_q.size() > 0) ? src_q[0] : DW'($urandom);
    out_full = force_full | ((full_mode != 0) && ($urandom_range(0, 3) == 0));
  end

  // ---------------- reference model + scoreboard ----------------
  logic [DW-1:0]   pix [H][W];
  logic [3*DW-1:0] exp_q[$];
  logic [3*DW-1:0] got_q[$];
  logic [3*DW-1:0] ref_q[$];
  int mr = 0, mc = 0;
  bit exp_done = 0;
  int n_cons = 0, n_done = 0, cyc = 0;
  int c20_cyc = -1, first_wr_cyc = -1;

  // Sample mid-cycle: what the DUT will do at the next rising edge.
  always @(negedge clock) begin
    logic [3*DW-1:0] e;
    cyc++;
    if (!reset) begin
      mr = 0; mc = 0; exp_q.delete(); exp_done = 0; took = 0;
    end else begin
      check("frame_done", frame_done, exp_done);
      if (frame_done) n_done++;
      if (out_full) check("wr_while_full", out_wr_en, 0);
      if (out_wr_en) begin
        if (exp_q.size() == 0) check("extra_write", out_din, 32'hdead);
        else begin
          e = exp_q.pop_front();
          check("out_din", out_din, e);
        end
        if (first_wr_cyc < 0) first_wr_cyc = cyc;
        got_q.push_back(out_din);
      end
      took = in_rd_en && !in_empty;
      exp_done = 0;
      if (in_rd_en) begin
        check("rd_on_empty", in_empty, 0);
        pix[mr][mc] = in_dout;
        if (mr >= 2) exp_q.push_back({in_dout, pix[mr-1][mc], pix[mr-2][mc]});
`ifdef LINE_BUFFER_ZERO_PAD_EN
        else if (mr == 1) exp_q.push_back({in_dout, pix[0][mc], 8'h00});
        else exp_q.push_back({in_dout, 16'h0000});
`endif
        if (mr == 2 && mc == 0 && c20_cyc < 0) c20_cyc = cyc;
        n_cons++;
        if (mc == W - 1) begin
          mc = 0;
          if (mr == H - 1) begin mr = 0; exp_done = 1; end
          else mr++;
        end else mc++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_rec();
    got_q.delete(); n_cons = 0; n_done = 0; c20_cyc = -1; first_wr_cyc = -1;
  endtask

  task automatic push_frame(input bit rnd);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        src_q.push_back(rnd ? DW'($urandom) : DW'(16 * r + c));
  endtask

  task automatic wait_drain();
    int budget = 3000;
    while ((src_q.size() > 0 || exp_q.size() > 0) && budget > 0) begin
      @(negedge clock); #1; budget--;
    end
    if (budget == 0) check("drain_timeout", 1, 0);
    repeat (4) @(negedge clock);
    #1;
  endtask

  task automatic wait_cons(input int n);
    int budget = 1000;
    while (n_cons < n && budget > 0) begin
      @(negedge clock); #1; budget--;
    end
    if (budget == 0) check("cons_timeout", 1, 0);
  endtask

  task automatic compare_ref(input string name, input int off);
    check({name, "_count"}, got_q.size() >= off + NOUT, 1);
    for (int i = 0; i < NOUT && off + i < got_q.size() && i < ref_q.size(); i++)
      check(name, got_q[off + i], ref_q[i]);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    // reset state
    repeat (3) @(negedge clock);
    check("rst_out_din", out_din, 0);
    check("rst_wr_en", out_wr_en, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_rd_en", in_rd_en, 0);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    // test 1: plain frame
    clear_rec(); push_frame(0); wait_drain();
    check("t1_writes", got_q.size(), NOUT);
    check("t1_frame_done", n_done, 1);
`ifdef LINE_BUFFER_ZERO_PAD_EN
    if (got_q.size() == NOUT) begin
      check("t1_first", got_q[0], 24'h000000);
      check("t1_second", got_q[1], 24'h010000);
      check("t1_r1c2", got_q[6], 24'h120200);
      check("t1_r3c0", got_q[12], 24'h302010);
      check("t1_last", got_q[15], 24'h332313);
    end
`else
    if (got_q.size() == NOUT) begin
      check("t1_first", got_q[0], 24'h201000);
      check("t1_r2c1", got_q[1], 24'h211101);
      check("t1_last", got_q[7], 24'h332313);
    end
    check("t1_latency", first_wr_cyc - c20_cyc, 1);
`endif
    ref_q = got_q;

    // test 2: stall mid-STREAM
    begin
      logic [3*DW-1:0] hold;
      clear_rec(); push_frame(0);
      wait_cons(10);
      force_full = 1;
      for (int i = 0; i < 5; i++) begin
        @(negedge clock); #1;
        if (i == 0) hold = out_din;
        check("t2_stable", out_din, hold);
        check("t2_rd_en", in_rd_en, 0);
        check("t2_wr_en", out_wr_en, 0);
      end
      force_full = 0;
      wait_drain();
      compare_ref("t2_seq", 0);
    end

    // test 3: in_empty toggling
    clear_rec(); empty_mode = 1; push_frame(0); wait_drain(); empty_mode = 0;
    compare_ref("t3_seq", 0);

    // test 4: two frames back-to-back
    clear_rec(); push_frame(0); push_frame(0); wait_drain();
    check("t4_writes", got_q.size(), 2 * NOUT);
    check("t4_frame_done", n_done, 2);
    compare_ref("t4_f0", 0);
    compare_ref("t4_f1", NOUT);

    // test 5: reset during row 2
    clear_rec(); push_frame(0);
    wait_cons(9);
    #2 reset = 1'b0;
    #1;
    check("t5_wr_en", out_wr_en, 0);
    check("t5_out_din", out_din, 0);
    check("t5_frame_done", frame_done, 0);
    src_q.delete();
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    clear_rec(); push_frame(0); wait_drain();
    check("t5_writes", got_q.size(), NOUT);
    compare_ref("t5_seq", 0);

    // test 6: random pixels with random gaps and backpressure
    clear_rec(); empty_mode = 2; full_mode = 1;
    push_frame(1); push_frame(1); wait_drain();
    empty_mode = 0; full_mode = 0;
    repeat (4) @(negedge clock);
    check("t6_writes", got_q.size(), 2 * NOUT);
    check("t6_frame_done", n_done, 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
